rob_commit: RTL and testbench

- Reorder buffer at the other end of the register file's rename/writeback interface.
- Hands out ROB tags to the decoder at issue; the decoder renames rd to that tag in the regfile.
- Collects execution results from the CDB and retires entries strictly in order, driving the regfile commit port (rob_wr_*).
- On a mispredicted branch at commit, raises the rollback pulse that clears all regfile rename tags.

---
 rtl/rob_commit.sv | 126 ++++++++++++
 tb/tb_rob_commit.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_commit.sv
// rob_commit: reorder buffer that allocates tags, collects CDB results and retires in order
module rob_commit #(
  parameter int ROB_BIT  = 4,
  parameter int ROB_SIZE = 1 << ROB_BIT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_rdy,
  input  logic               i_iss_ena,
  input  logic               i_iss_has_rd,
  input  logic [4:0]         i_iss_rd,
  input  logic               i_iss_is_br,
  input  logic               i_iss_pred,
  input  logic [31:0]        i_iss_alt_pc,
  output logic [ROB_BIT-1:0] o_alloc_idx,
  output logic               o_rob_full,
  input  logic               i_cdb_ena,
  input  logic [ROB_BIT-1:0] i_cdb_idx,
  input  logic [31:0]        i_cdb_val,
  input  logic               i_cdb_taken,
  input  logic [ROB_BIT-1:0] i_qry_idx1,
  input  logic [ROB_BIT-1:0] i_qry_idx2,
  output logic               o_qry_rdy1,
  output logic               o_qry_rdy2,
  output logic [31:0]        o_qry_val1,
  output logic [31:0]        o_qry_val2,
  output logic               o_rob_wr_ena,
  output logic [4:0]         o_rob_wr_rd,
  output logic [31:0]        o_rob_wr_val,
  output logic [ROB_BIT-1:0] o_rob_wr_idx,
  output logic               o_rob_rb,
  output logic [31:0]        o_rob_rb_pc
);
  localparam logic [ROB_BIT-1:0] LAST = ROB_BIT'(ROB_SIZE - 1);
  localparam logic [ROB_BIT-1:0] ONE  = ROB_BIT'(1);
  // tag 0 means "no producer", so the ring skips it
  function automatic logic [ROB_BIT-1:0] f_next(input logic [ROB_BIT-1:0] i);
    return (i == LAST) ? ONE : i + ONE;
  endfunction
  logic [ROB_BIT-1:0]  r_head, r_tail, r_count;
  logic [ROB_SIZE-1:0] r_valid, r_ready, r_has_rd, r_is_br, r_pred, r_taken;
  logic [4:0]          r_rd     [ROB_SIZE];
  logic [31:0]         r_val    [ROB_SIZE];
  logic [31:0]         r_alt_pc [ROB_SIZE];
  logic                r_wr_ena, r_rb;
  logic [4:0]          r_wr_rd;
  logic [31:0]         r_wr_val, r_rb_pc;
  logic [ROB_BIT-1:0]  r_wr_idx;
  logic                w_commit, w_mis, w_alloc, w_wb, w_fwd1, w_fwd2;
  logic [ROB_SIZE-1:0] w_valid_nxt, w_ready_nxt;
  assign w_commit = (r_count != '0) && r_valid[r_head] && r_ready[r_head];
  assign w_mis    = w_commit && r_is_br[r_head] && (r_taken[r_head] != r_pred[r_head]);
  assign w_alloc  = i_iss_ena && !o_rob_full;
  assign w_wb     = i_cdb_ena && r_valid[i_cdb_idx];
  assign w_fwd1   = i_cdb_ena && (i_cdb_idx == i_qry_idx1);
  assign w_fwd2   = i_cdb_ena && (i_cdb_idx == i_qry_idx2);
  assign o_alloc_idx  = r_tail;
  assign o_rob_full   = (r_count == LAST);
  assign o_qry_rdy1   = (i_qry_idx1 == '0) || w_fwd1 || (r_valid[i_qry_idx1] && r_ready[i_qry_idx1]);
  assign o_qry_rdy2   = (i_qry_idx2 == '0) || w_fwd2 || (r_valid[i_qry_idx2] && r_ready[i_qry_idx2]);
  assign o_qry_val1   = (i_qry_idx1 == '0) ? '0 : w_fwd1 ? i_cdb_val : r_val[i_qry_idx1];
  assign o_qry_val2   = (i_qry_idx2 == '0) ? '0 : w_fwd2 ? i_cdb_val : r_val[i_qry_idx2];
  assign o_rob_wr_ena = r_wr_ena;
  assign o_rob_wr_rd  = r_wr_rd;
  assign o_rob_wr_val = r_wr_val;
  assign o_rob_wr_idx = r_wr_idx;
  assign o_rob_rb     = r_rb;
  assign o_rob_rb_pc  = r_rb_pc;
  // next valid/ready bits: retire head, claim tail, mark written-back entries ready
  always_comb begin
    w_valid_nxt = r_valid;
    w_ready_nxt = r_ready;
    if (w_commit) w_valid_nxt[r_head] = 1'b0;
    if (w_alloc) w_valid_nxt[r_tail] = 1'b1;
    if (w_alloc) w_ready_nxt[r_tail] = 1'b0;
    if (w_wb) w_ready_nxt[i_cdb_idx] = 1'b1;
  end
  // queue pointers and status bits; a mispredict at commit empties the whole buffer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head  <= ONE;
      r_tail  <= ONE;
      r_count <= '0;
      r_valid <= '0;
      r_ready <= '0;
    end else if (i_rdy) begin
      r_head  <= w_mis ? ONE : w_commit ? f_next(r_head) : r_head;
      r_tail  <= w_mis ? ONE : w_alloc ? f_next(r_tail) : r_tail;
      r_count <= w_mis ? '0 : r_count + ROB_BIT'(w_alloc) - ROB_BIT'(w_commit);
      r_valid <= w_mis ? '0 : w_valid_nxt;
      r_ready <= w_mis ? '0 : w_ready_nxt;
    end
  end
  // entry payload; only meaningful while the entry is valid, so it needs no reset
  always_ff @(posedge clk) begin
    if (i_rdy && !w_mis && w_alloc) begin
      r_has_rd[r_tail] <= i_iss_has_rd;
      r_rd[r_tail]     <= i_iss_rd;
      r_is_br[r_tail]  <= i_iss_is_br;
      r_pred[r_tail]   <= i_iss_pred;
      r_alt_pc[r_tail] <= i_iss_alt_pc;
    end
    if (i_rdy && !w_mis && w_wb) begin
      r_val[i_cdb_idx]   <= i_cdb_val;
      r_taken[i_cdb_idx] <= i_cdb_taken;
    end
  end
  // registered commit port and rollback pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ena <= 1'b0;
      r_wr_rd  <= '0;
      r_wr_val <= '0;
      r_wr_idx <= '0;
      r_rb     <= 1'b0;
      r_rb_pc  <= '0;
    end else if (i_rdy) begin
      r_wr_ena <= w_commit && r_has_rd[r_head] && (r_rd[r_head] != '0);
      r_wr_rd  <= w_commit ? r_rd[r_head] : r_wr_rd;
      r_wr_val <= w_commit ? r_val[r_head] : r_wr_val;
      r_wr_idx <= w_commit ? r_head : r_wr_idx;
      r_rb     <= w_mis;
      r_rb_pc  <= w_mis ? r_alt_pc[r_head] : r_rb_pc;
    end
  end
endmodule

// File: tb/tb_rob_commit.sv
// tb_rob_commit: random and directed stimulus against an in-order queue model with a commit scoreboard
module tb_rob_commit;
  logic        clk = 1'b0;
  logic        rst, rdy, iss_ena, iss_has_rd, iss_is_br, iss_pred, cdb_ena, cdb_taken;
  logic [4:0]  iss_rd;
  logic [31:0] iss_alt_pc, cdb_val;
  logic [3:0]  cdb_idx, qry_idx1, qry_idx2;
  logic [3:0]  alloc_idx, wr_idx;
  logic        rob_full, qry_rdy1, qry_rdy2, wr_ena, rb;
  logic [31:0] qry_val1, qry_val2, wr_val, rb_pc;
  logic [4:0]  wr_rd;

  rob_commit dut (
    .clk(clk), .rst(rst), .i_rdy(rdy),
    .i_iss_ena(iss_ena), .i_iss_has_rd(iss_has_rd), .i_iss_rd(iss_rd),
    .i_iss_is_br(iss_is_br), .i_iss_pred(iss_pred), .i_iss_alt_pc(iss_alt_pc),
    .o_alloc_idx(alloc_idx), .o_rob_full(rob_full),
    .i_cdb_ena(cdb_ena), .i_cdb_idx(cdb_idx), .i_cdb_val(cdb_val), .i_cdb_taken(cdb_taken),
    .i_qry_idx1(qry_idx1), .i_qry_idx2(qry_idx2),
    .o_qry_rdy1(qry_rdy1), .o_qry_rdy2(qry_rdy2), .o_qry_val1(qry_val1), .o_qry_val2(qry_val2),
    .o_rob_wr_ena(wr_ena), .o_rob_wr_rd(wr_rd), .o_rob_wr_val(wr_val), .o_rob_wr_idx(wr_idx),
    .o_rob_rb(rb), .o_rob_rb_pc(rb_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] tag; bit has_rd; logic [4:0] rd; bit is_br; bit pred;
    logic [31:0] alt; bit rdy; logic [31:0] val; bit taken;
  } ent_t;
  typedef struct {
    bit wr; logic [4:0] rd; logic [31:0] val; logic [3:0] idx; bit rb; logic [31:0] pc;
  } exp_t;

  ent_t rob[$];
  exp_t sb[$];
  logic [3:0] m_tail = 4'd1;
  bit last_rdy = 1'b1;
  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] nxt(input logic [3:0] t);
    return (t == 4'd15) ? 4'd1 : t + 4'd1;
  endfunction

  function automatic void mq(input logic [3:0] q, output bit r, output logic [31:0] v);
    r = 0; v = 0;
    if (q == 0) r = 1;
    else if (cdb_ena && cdb_idx == q) begin r = 1; v = cdb_val; end
    else foreach (rob[i]) if (rob[i].tag == q && rob[i].rdy) begin r = 1; v = rob[i].val; end
  endfunction

  // reference behaviour for one clock edge, using the inputs presented before it
  task automatic model_edge();
    bit full, mis;
    exp_t e;
    ent_t n;
    last_rdy = rdy;
    if (!rdy) return;
    full = rob.size() == 15;
    mis = 0;
    if (rob.size() > 0 && rob[0].rdy) begin
      e.wr = rob[0].has_rd && rob[0].rd != 0;
      e.rd = rob[0].rd; e.val = rob[0].val; e.idx = rob[0].tag;
      mis = rob[0].is_br && rob[0].taken != rob[0].pred;
      e.rb = mis; e.pc = rob[0].alt;
      if (e.wr || mis) sb.push_back(e);
      void'(rob.pop_front());
    end
    if (mis) begin rob.delete(); m_tail = 4'd1; return; end
    if (cdb_ena) foreach (rob[i]) if (rob[i].tag == cdb_idx) begin
      rob[i].rdy = 1; rob[i].val = cdb_val; rob[i].taken = cdb_taken;
    end
    if (iss_ena && !full) begin
      n.tag = m_tail; n.has_rd = iss_has_rd; n.rd = iss_rd; n.is_br = iss_is_br;
      n.pred = iss_pred; n.alt = iss_alt_pc; n.rdy = 0; n.val = 0; n.taken = 0;
      rob.push_back(n);
      m_tail = nxt(m_tail);
    end
  endtask

  task automatic step();
    bit r; logic [31:0] v;
    #1;
    chk("alloc_idx", alloc_idx, m_tail);
    chk("rob_full", rob_full, rob.size() == 15);
    mq(qry_idx1, r, v);
    chk("qry_rdy1", qry_rdy1, r);
    if (r) chk("qry_val1", qry_val1, v);
    mq(qry_idx2, r, v);
    chk("qry_rdy2", qry_rdy2, r);
    if (r) chk("qry_val2", qry_val2, v);
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    rdy = 1; iss_ena = 0; iss_has_rd = 0; iss_rd = 0; iss_is_br = 0; iss_pred = 0;
    iss_alt_pc = 0; cdb_ena = 0; cdb_idx = 0; cdb_val = 0; cdb_taken = 0;
    qry_idx1 = 0; qry_idx2 = 0;
  endtask

  task automatic issue(input bit has_rd, input logic [4:0] rd, input bit is_br, input bit pred, input logic [31:0] alt);
    idle();
    iss_ena = 1; iss_has_rd = has_rd; iss_rd = rd; iss_is_br = is_br; iss_pred = pred; iss_alt_pc = alt;
    step();
  endtask

  task automatic wb(input logic [3:0] tag, input logic [31:0] val, input bit taken);
    idle();
    cdb_ena = 1; cdb_idx = tag; cdb_val = val; cdb_taken = taken;
    qry_idx1 = tag;
    step();
  endtask

  task automatic do_reset();
    #2 rst = 1;
    #1;
    chk("rst_wr_ena", wr_ena, 0);
    chk("rst_rb", rb, 0);
    chk("rst_rb_pc", rb_pc, 0);
    chk("rst_wr_val", wr_val, 0);
    chk("rst_alloc_idx", alloc_idx, 1);
    chk("rst_full", rob_full, 0);
    chk("rst_sb_empty", sb.size(), 0);
    rob.delete(); sb.delete(); m_tail = 4'd1;
    idle();
    @(posedge clk); @(posedge clk); @(negedge clk);
    rst = 0;
  endtask

  // write back every outstanding entry youngest first, then let the buffer retire
  task automatic drain();
    logic [3:0] tags[$]; bit preds[$];
    int g;
    foreach (rob[i]) begin tags.push_back(rob[i].tag); preds.push_back(rob[i].pred); end
    for (int i = tags.size() - 1; i >= 0; i--) wb(tags[i], $urandom, preds[i]);
    idle();
    g = 0;
    while (rob.size() > 0 && g < 40) begin step(); g++; end
    chk("drain_empty", rob.size(), 0);
    step();
  endtask

  // scoreboard monitor: fresh outputs after an active edge are matched against queued commits
  logic        p_wr_ena, p_rb;
  logic [4:0]  p_wr_rd;
  logic [31:0] p_wr_val, p_rb_pc;
  logic [3:0]  p_wr_idx;
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (!last_rdy) begin
        chk("hold_wr_ena", wr_ena, p_wr_ena);
        chk("hold_wr_rd", wr_rd, p_wr_rd);
        chk("hold_wr_val", wr_val, p_wr_val);
        chk("hold_wr_idx", wr_idx, p_wr_idx);
        chk("hold_rb", rb, p_rb);
        chk("hold_rb_pc", rb_pc, p_rb_pc);
      end else if (sb.size() == 0) begin
        chk("spurious_wr_ena", wr_ena, 0);
        chk("spurious_rb", rb, 0);
      end else begin
        e = sb.pop_front();
        chk("wr_ena", wr_ena, e.wr);
        if (e.wr) begin
          chk("wr_rd", wr_rd, e.rd);
          chk("wr_val", wr_val, e.val);
          chk("wr_idx", wr_idx, e.idx);
        end
        chk("rb", rb, e.rb);
        if (e.rb) chk("rb_pc", rb_pc, e.pc);
      end
    end
    p_wr_ena = wr_ena; p_wr_rd = wr_rd; p_wr_val = wr_val; p_wr_idx = wr_idx; p_rb = rb; p_rb_pc = rb_pc;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] t;
    int k;
    rst = 1;
    idle();
    do_reset();
    // single instruction round trip
    issue(1, 5'd5, 0, 0, 0);
    wb(4'd1, 32'hDEAD, 0);
    idle(); step(); step();
    // fill to capacity, sixteenth issue ignored, tags wrap past 15
    for (int i = 0; i < 16; i++) issue(1, 5'($urandom_range(1, 31)), 0, 0, 0);
    idle(); step();
    drain();
    // out-of-order completion from a clean start
    do_reset();
    for (int i = 0; i < 3; i++) issue(1, 5'(i + 1), 0, 0, 0);
    drain();
    // mispredicted branch with younger entries, then a stale writeback to a flushed tag
    do_reset();
    issue(1, 5'd3, 1, 0, 32'h1000);
    issue(1, 5'd4, 0, 0, 0);
    issue(1, 5'd6, 0, 0, 0);
    wb(4'd1, 32'h11, 1);
    idle(); step(); step();
    wb(4'd2, 32'h22, 0);
    idle(); qry_idx1 = 4'd2; step();
    // same-cycle forwarding and a three-cycle rdy stall
    do_reset();
    for (int i = 0; i < 4; i++) issue(1, 5'(i + 8), 0, 0, 0);
    idle(); cdb_ena = 1; cdb_idx = 4'd4; cdb_val = 32'd7; qry_idx1 = 4'd4; qry_idx2 = 4'd3; step();
    wb(4'd1, 32'hA1, 0);
    idle(); cdb_ena = 1; cdb_idx = 4'd2; cdb_val = 32'hA2; rdy = 0; step();
    idle(); rdy = 0; step();
    idle(); rdy = 0; qry_idx1 = 4'd1; step();
    idle(); step();
    drain();
    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 399) == 0) do_reset();
      idle();
      rdy = $urandom_range(0, 9) != 0;
      iss_ena = 1'($urandom_range(0, 1));
      iss_has_rd = $urandom_range(0, 3) != 0;
      iss_rd = 5'($urandom);
      iss_is_br = $urandom_range(0, 4) == 0;
      iss_pred = 1'($urandom_range(0, 1));
      iss_alt_pc = $urandom;
      cdb_val = $urandom;
      if (rob.size() > 0 && $urandom_range(0, 2) != 0) begin
        k = $urandom_range(0, rob.size() - 1);
        cdb_ena = 1;
        cdb_idx = rob[k].tag;
        cdb_taken = rob[k].is_br ? ($urandom_range(0, 5) == 0 ? !rob[k].pred : rob[k].pred) : 1'($urandom_range(0, 1));
      end else if ($urandom_range(0, 4) == 0) begin
        cdb_ena = 1; cdb_idx = 4'($urandom); cdb_taken = 1'($urandom_range(0, 1));
      end
      t = 4'($urandom);
      qry_idx1 = t;
      qry_idx2 = ($urandom_range(0, 1) != 0) ? cdb_idx : 4'($urandom);
      step();
    end
    idle();
    drain();
    step(); step();
    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
